data_cache_wb_block: RTL

DATA_CACHE_WB_BLOCK -- requirements
Module: data_cache_wb_block

---
 rtl/data_cache_wb_block.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_cache_wb_block.sv
// Write-back data cache store: byte-enabled CPU writes, beat refills and a flush sweep FSM.
// Define DATA_CACHE_WB_SKIP_CLEAN_EN to make the sweep write back only dirty beats.
module data_cache_wb_block #(
    parameter int ADDR_WIDTH = 6,
    parameter int BEAT_WORDS = 4,
    localparam int BEAT_COUNT = (2 ** ADDR_WIDTH) / BEAT_WORDS,
    localparam int BW         = $clog2(BEAT_COUNT),
    localparam int WSEL       = $clog2(BEAT_WORDS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [BW-1:0]             addr_r_i,
    output logic [32*BEAT_WORDS-1:0]  data_r_o,
    input  logic [ADDR_WIDTH-1:0]     addr_w_i,
    input  logic [31:0]               data_w_i,
    input  logic [3:0]                write_en_i,
    input  logic                      fill_valid_i,
    output logic                      fill_ready_o,
    input  logic [BW-1:0]             fill_addr_i,
    input  logic [32*BEAT_WORDS-1:0]  fill_data_i,
    input  logic                      flush_req_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [BW-1:0]             wb_addr_o,
    output logic [32*BEAT_WORDS-1:0]  wb_data_o,
    output logic                      busy_o,
    output logic                      flush_done_o,
    output logic [BEAT_COUNT-1:0]     dirty_o
);

    typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

    localparam logic [BW-1:0] LAST = BW'(BEAT_COUNT - 1);

    state_t                     state, state_n;
    logic [BW-1:0]              ptr, ptr_n;
    logic                       stale;
    logic [BEAT_COUNT-1:0]      dirty;
    logic [31:0]                mem [BEAT_COUNT][BEAT_WORDS];
    logic [32*BEAT_WORDS-1:0]   ptr_data;
    logic [BW-1:0]              cpu_beat;
    logic [WSEL-1:0]            cpu_word;
    logic                       cpu_we, cpu_hits_ptr, fill_fire, load_wb, wb_fire, select;

    assign cpu_beat     = addr_w_i[ADDR_WIDTH-1:WSEL];
    assign cpu_word     = addr_w_i[WSEL-1:0];
    assign cpu_we       = |write_en_i;
    assign cpu_hits_ptr = cpu_we && (cpu_beat == ptr);
    assign fill_ready_o = ~busy_o;
    assign fill_fire    = fill_valid_i & fill_ready_o;
    assign dirty_o      = dirty;

`ifdef DATA_CACHE_WB_SKIP_CLEAN_EN
    assign select = dirty[ptr];
`else
    assign select = 1'b1;
`endif

    // NOTE: storage is deliberately left out of reset so it maps onto plain RAM cells.
    // NOTE: non-blocking assignments resolve in order, so the CPU bytes written after the
    // refill word win when both target the same beat in one cycle.
    always_ff @(posedge clk_i) begin
        if (fill_fire) begin
            for (int k = 0; k < BEAT_WORDS; k++)
                mem[fill_addr_i][k] <= fill_data_i[32*k +: 32];
        end
        for (int b = 0; b < 4; b++) begin
            if (write_en_i[b])
                mem[cpu_beat][cpu_word][8*b +: 8] <= data_w_i[8*b +: 8];
        end
    end

    always_comb begin
        for (int k = 0; k < BEAT_WORDS; k++) begin
            data_r_o[32*k +: 32] = mem[addr_r_i][k];
            ptr_data[32*k +: 32] = mem[ptr][k];
        end
    end

    // Captured copy: later CPU writes to the beat must not disturb an offered writeback.
    always_ff @(posedge clk_i) begin
        if (load_wb) begin
            wb_addr_o <= ptr;
            wb_data_o <= ptr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr   <= '0;
            stale <= 1'b0;
            dirty <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            // A write landing on the selection edge is already missing from the captured copy.
            if (load_wb)
                stale <= cpu_hits_ptr;
            else if (state == SEND && cpu_hits_ptr)
                stale <= 1'b1;
            if (fill_fire)
                dirty[fill_addr_i] <= 1'b0;
            if (wb_fire && !stale)
                dirty[ptr] <= 1'b0;
            if (cpu_we)
                dirty[cpu_beat] <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        load_wb      = 1'b0;
        wb_fire      = 1'b0;
        wb_valid_o   = 1'b0;
        flush_done_o = 1'b0;
        busy_o       = (state != IDLE);
        case (state)
            IDLE: begin
                if (flush_req_i) begin
                    state_n = SCAN;
                    ptr_n   = '0;
                end
            end
            SCAN: begin
                if (select) begin
                    load_wb = 1'b1;
                    state_n = SEND;
                end else if (ptr == LAST) begin
                    state_n = DONE;
                end else begin
                    ptr_n = ptr + BW'(1);
                end
            end
            SEND: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    wb_fire = 1'b1;
                    if (ptr == LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = SCAN;
                        ptr_n   = ptr + BW'(1);
                    end
                end
            end
            DONE: begin
                flush_done_o = 1'b1;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
